music_score_sequencer: RTL and testbench

MUSIC_SCORE_SEQUENCER -- requirements
Module: music_score_sequencer

---
 rtl/music_score_sequencer.sv | 149 ++++++++++++++
 tb/tb_music_score_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/music_score_sequencer.sv
// music_score_sequencer
//   Plays a small score of {note, len} entries. Each entry sounds for len beats.
//   A beat is TICKS_PER_BEAT clock cycles long. An entry with len == 0 marks the
//   end of the score. The score can be rewritten at any time through a simple
//   write port.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   start, stop          single-cycle play / abort requests (stop wins)
//   pause                level; freezes beat timing while high
//   loop_en              level; wrap to entry 0 at end of score
//   wr_en/addr/note/len  score write port (len 0 = end marker)
//   note                 registered current note code (0 = silence)
//   beat_pulse           one cycle high on each completed beat in PLAY
//   playing, done        state decodes (PLAY|PAUSE, DONE)
//   cur_idx              index of the sounding entry
module music_score_sequencer #(
  parameter int NOTE_W         = 5,
  parameter int LEN_W          = 4,
  parameter int DEPTH          = 32,
  parameter int TICKS_PER_BEAT = 25000000,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [NOTE_W-1:0] wr_note,
  input  logic [LEN_W-1:0]  wr_len,
  output logic [NOTE_W-1:0] note,
  output logic              beat_pulse,
  output logic              playing,
  output logic              done,
  output logic [AW-1:0]     cur_idx
);

  // clog2(T) bits always hold T-1
  localparam int TW = $clog2(TICKS_PER_BEAT);

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [LEN_W-1:0]  len;
  } entry_t;

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, DONE} state_t;

  entry_t             score [DEPTH];
  state_t             state;
  logic [TW-1:0]      tick;
  logic [LEN_W-1:0]   rem;

  logic               beat_done;
  logic               last;
  logic               end_stop;
  logic               entry0_ok;
  logic [AW-1:0]      nxt;
  logic [AW-1:0]      ld_idx;

  // Score storage; writable in every state. The sounding note/rem are
  // private copies, so rewriting the current entry only affects its next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) score[i] <= '0;
    end else if (wr_en) begin
      score[wr_addr] <= '{note: wr_note, len: wr_len};
    end
  end

  always_comb begin
    beat_done = (state == PLAY) && !pause && (tick == TW'(TICKS_PER_BEAT - 1));
    nxt       = cur_idx + 1'b1;
    entry0_ok = (score[0].len != '0);
    // last slot never wraps through to entry 0 on its own
    last      = (cur_idx == AW'(DEPTH - 1)) || (score[nxt].len == '0);
    ld_idx    = last ? '0 : nxt;
    end_stop  = last && !(loop_en && entry0_ok);
  end

  // Pulse marks the cycle in which the beat completes; the next entry shows
  // up on note/cur_idx one cycle later.
  assign beat_pulse = beat_done && !stop;
  assign playing    = (state == PLAY) || (state == PAUSE);
  assign done       = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      note    <= '0;
      cur_idx <= '0;
      tick    <= '0;
      rem     <= '0;
    end else if (stop) begin
      state   <= IDLE;
      note    <= '0;
      cur_idx <= '0;
      tick    <= '0;
      rem     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            tick    <= '0;
            cur_idx <= '0;
            if (entry0_ok) begin
              state <= PLAY;
              note  <= score[0].note;
              rem   <= score[0].len;
            end else begin
              state <= DONE;
              note  <= '0;
              rem   <= '0;
            end
          end
        end
        PLAY: begin
          if (pause) begin
            state <= PAUSE;
          end else if (tick == TW'(TICKS_PER_BEAT - 1)) begin
            tick <= '0;
            if (rem <= LEN_W'(1)) begin
              if (end_stop) begin
                state <= DONE;
                note  <= '0;
                rem   <= '0;
              end else begin
                note    <= score[ld_idx].note;
                rem     <= score[ld_idx].len;
                cur_idx <= ld_idx;
              end
            end else begin
              rem <= rem - 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        PAUSE: begin
          if (!pause) state <= PLAY;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_music_score_sequencer.sv
// Directed bench for music_score_sequencer (TICKS_PER_BEAT=4, DEPTH=8).
// Inputs change and outputs are sampled on the falling edge.
module tb_music_score_sequencer;

  localparam int NOTE_W = 5;
  localparam int LEN_W  = 4;
  localparam int DEPTH  = 8;
  localparam int TPB    = 4;
  localparam int AW     = 3;

  logic              clk = 1'b0;
  logic              rst, start, stop, pause, loop_en, wr_en;
  logic [AW-1:0]     wr_addr;
  logic [NOTE_W-1:0] wr_note;
  logic [LEN_W-1:0]  wr_len;
  logic [NOTE_W-1:0] note;
  logic              beat_pulse, playing, done;
  logic [AW-1:0]     cur_idx;

  int n_run  = 0;
  int n_fail = 0;
  int pulses;

  always #5 clk = ~clk;

  music_score_sequencer #(
    .NOTE_W(NOTE_W), .LEN_W(LEN_W), .DEPTH(DEPTH), .TICKS_PER_BEAT(TPB)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .loop_en(loop_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note),
    .wr_len(wr_len), .note(note), .beat_pulse(beat_pulse), .playing(playing),
    .done(done), .cur_idx(cur_idx)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wr(input int a, input int n, input int l);
    wr_en = 1'b1; wr_addr = AW'(a); wr_note = NOTE_W'(n); wr_len = LEN_W'(l);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 0; stop = 0; pause = 0; loop_en = 0; wr_en = 0;
    wr_addr = '0; wr_note = '0; wr_len = '0;
    repeat (2) @(negedge clk);
    chk("rst_note", note, 0);
    chk("rst_playing", playing, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", cur_idx, 0);
    chk("rst_pulse", beat_pulse, 0);
    rst = 1'b0;
    @(negedge clk);

    // basic score: note1 x2 beats, note3 x1 beat, end
    wr(0, 1, 2); wr(1, 3, 1); wr(2, 7, 0);
    pulse_start();
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      chk("play_note", note, (i < 8) ? 1 : 3);
      chk("play_pulse", beat_pulse, (i % 4 == 3) ? 1 : 0);
      chk("play_playing", playing, 1);
      pulses += int'(beat_pulse);
      @(negedge clk);
    end
    chk("pulse_count", pulses, 3);
    chk("end_done", done, 1);
    chk("end_note", note, 0);
    chk("end_idx", cur_idx, 1);
    chk("end_playing", playing, 0);

    // looping; a start mid-play must be ignored
    loop_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 30; i++) begin
      chk("loop_note", note, (i % 12 < 8) ? 1 : 3);
      chk("loop_idx", cur_idx, (i % 12 < 8) ? 0 : 1);
      start = (i == 5);
      @(negedge clk);
    end
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("stop_note", note, 0);
    chk("stop_playing", playing, 0);
    chk("stop_done", done, 0);
    chk("stop_idx", cur_idx, 0);
    loop_en = 1'b0;

    // pause in the middle of the first beat (tick 2)
    pulse_start();
    @(negedge clk); @(negedge clk);
    chk("pre_pause_note", note, 1);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("pause_note", note, 1);
      chk("pause_pulse", beat_pulse, 0);
      chk("pause_playing", playing, 1);
    end
    pause = 1'b0;
    @(negedge clk);
    // back in PLAY at tick 2: pulse after one more cycle, then a full beat
    for (int j = 0; j < 6; j++) begin
      chk("resume_note", note, 1);
      chk("resume_pulse", beat_pulse, (j == 1 || j == 5) ? 1 : 0);
      @(negedge clk);
    end
    chk("resume_next_note", note, 3);
    pulse_stop();

    // all eight entries one beat each, no loop
    for (int k = 0; k < DEPTH; k++) wr(k, k + 1, 1);
    pulse_start();
    for (int c = 0; c < 32; c++) begin
      if (c % 4 == 0) begin
        chk("full_note", note, c / 4 + 1);
        chk("full_idx", cur_idx, c / 4);
      end
      @(negedge clk);
    end
    chk("full_done", done, 1);
    chk("full_idx_end", cur_idx, 7);
    chk("full_note_end", note, 0);

    // empty score from IDLE goes straight to DONE
    pulse_stop();
    wr(0, 5, 0);
    pulse_start();
    chk("empty_done", done, 1);
    chk("empty_note", note, 0);
    chk("empty_playing", playing, 0);

    // asynchronous reset mid-note
    pulse_stop();
    wr(0, 1, 2);
    pulse_start();
    repeat (5) @(negedge clk);
    chk("pre_rst_playing", playing, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_note", note, 0);
    chk("arst_playing", playing, 0);
    chk("arst_done", done, 0);
    chk("arst_idx", cur_idx, 0);
    chk("arst_pulse", beat_pulse, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    chk("post_rst_done", done, 1);
    chk("post_rst_note", note, 0);
    chk("post_rst_playing", playing, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
